// File: rtl/maxterm_pkg.sv
// Shared definitions for the maxterm scanner: state encoding and default sweep geometry.
package maxterm_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 1;
    localparam int TT_W       = 2 ** N_IN_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/maxterm_tarayici_settle_timer.sv
// Settle timer: reloads on every new code and flags the edge on which the
// function output has been stable for SETTLE cycles.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic sample_en
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count reached while the scanner is driving a code.
    assign sample_en = en && (cnt == '0);

endmodule

// File: rtl/maxterm_tarayici.sv
// Maxterm scanner: sweeps every input code of a combinational function, records its
// truth table and streams each code where the function is 0 over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start; results of the last sweep held
//   DRIVE | code on abcd_o, waiting for settle, then sampling x_i
//   EMIT  | maxterm index offered on mt_idx until accepted
//   DONE  | one-cycle completion pulse, then back to IDLE
module maxterm_tarayici
    import maxterm_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      abcd_o,
    input  logic                 x_i,
    output logic                 mt_valid,
    input  logic                 mt_ready,
    output logic [N_IN-1:0]      mt_idx,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt_mask,
    output logic [N_IN:0]        mt_count
);

    localparam logic [N_IN-1:0] LAST_CODE = '1;

    state_t state;
    state_t state_nx;
    logic   sample_en;
    logic   timer_load;
    logic   last_code;

    assign last_code = (abcd_o == LAST_CODE);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .en        (state == ST_DRIVE),
        .sample_en (sample_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_DRIVE;
                    timer_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (sample_en) begin
                    if (!x_i) begin
                        state_nx = ST_EMIT;
                    end else if (last_code) begin
                        state_nx = ST_DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (mt_ready) begin
                    if (last_code) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx   = ST_DRIVE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_DRIVE, ST_EMIT: busy = 1'b1;
            ST_DONE:           done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Code counter, truth-table capture and maxterm handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abcd_o   <= '0;
            mt_valid <= 1'b0;
            mt_idx   <= '0;
            tt_mask  <= '0;
            mt_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        abcd_o   <= '0;
                        tt_mask  <= '0;
                        mt_count <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (sample_en) begin
                        tt_mask[abcd_o] <= x_i;
                        if (!x_i) begin
                            mt_idx   <= abcd_o;
                            mt_valid <= 1'b1;
                            mt_count <= mt_count + 1'b1;
                        end else if (!last_code) begin
                            abcd_o <= abcd_o + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (mt_ready) begin
                        mt_valid <= 1'b0;
                        if (!last_code) begin
                            abcd_o <= abcd_o + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    abcd_o <= '0;
                end
                default: begin
                    abcd_o <= '0;
                end
            endcase
        end
    end

endmodule
